// File: rtl/cla_nibble_seq.sv
// Bit-serial-by-nibble adder: one 4-bit carry-lookahead slice is reused NSLICE times,
// least-significant nibble first, with the slice carry-out registered between passes.
module cla_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg   // 0 = IDLE, 1 = RUN, 2 = DONE
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready/out_valid depend only on the state register, never on in_valid/out_ready,
    // and a producer must hold its payload stable until the transfer completes.

    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;

    logic [3:0] na;
    logic [3:0] nb;
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic       c4;
    logic [3:0] slice_s;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    always_comb begin
        na = '0;
        nb = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (k == KW'(i)) begin
                na = a_reg[4*i +: 4];
                nb = b_reg[4*i +: 4];
            end
        end
    end

    // Single carry-lookahead slice: every carry is a flat sum of generate/propagate terms.
    always_comb begin
        p    = na ^ nb;
        g    = na & nb;
        c[0] = carry_reg;
        c[1] = g[0] | (p[0] & carry_reg);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_reg);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_reg);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry_reg);
        slice_s = p ^ c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        k         <= '0;
                        sum       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (k == KW'(i)) begin
                            sum[4*i +: 4] <= slice_s;
                        end
                    end
                    carry_reg <= c4;
                    if (k == LAST) begin
                        cout  <= c4;
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    // Return to IDLE only; the next accept needs a separate IDLE cycle.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Bench for cla_nibble_seq at WIDTH 16, 4 and 32: directed carry/backpressure/reset
// cases and randomized traffic, checked against plain a + b + cin arithmetic.
module tb_cla_nibble_seq;

    logic clk;
    int   cyc;
    int   checks;
    int   failures;
    int   done_cnt;

    initial begin
        clk      = 1'b0;
        cyc      = 0;
        checks   = 0;
        failures = 0;
        done_cnt = 0;
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input int w, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL w%0d %s: got 0x%0h expected 0x%0h (cycle %0d)", w, name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input int w, input string name);
        checks++;
        failures++;
        $display("FAIL w%0d %s (cycle %0d)", w, name, cyc);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int W    = (gi == 0) ? 16 : ((gi == 1) ? 4 : 32);
        localparam int NS   = W / 4;
        localparam int KMID = (NS > 2) ? 2 : NS - 1;

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] sum;
        logic         cout;
        logic [1:0]   state_dbg;

        logic [W:0]   exp_q[$];
        int           acc_q[$];
        int           or_mode;
        bit           seen;
        bit           prev_hs;
        logic [W:0]   held;

        cla_nibble_seq #(.WIDTH(W)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .state_dbg (state_dbg)
        );

        // out_ready: 0 = held high, 1 = held low, other = random per cycle
        always @(posedge clk) begin
            #2;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end

        // Monitor: pops one expectation per presented result, checks hold and release.
        always @(negedge clk) begin
            if (rst_n) begin
                if (prev_hs) begin
                    chk(W, "in_ready after handshake", in_ready, 1);
                    chk(W, "out_valid after handshake", out_valid, 0);
                end
                prev_hs = 1'b0;
                if (out_valid) begin
                    chk(W, "in_ready while done", in_ready, 0);
                    if (!seen) begin
                        if (exp_q.size() == 0) begin
                            fail_now(W, "unexpected result");
                        end else begin
                            logic [W:0] e;
                            int         acc;
                            e   = exp_q.pop_front();
                            acc = acc_q.pop_front();
                            chk(W, "sum", sum, e[W-1:0]);
                            chk(W, "cout", cout, e[W]);
                            chk(W, "latency", cyc - acc, NS);
                        end
                        held = {cout, sum};
                        seen = 1'b1;
                    end else begin
                        chk(W, "result hold", {cout, sum}, held);
                    end
                    if (out_ready) begin
                        seen    = 1'b0;
                        prev_hs = 1'b1;
                    end
                end
            end
        end

        // While the block is busy, offer junk operands with random valid; otherwise stay quiet.
        task automatic idle_cycle();
            @(negedge clk);
            if (in_ready) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                a        = W'($urandom);
                b        = W'($urandom);
                cin      = 1'($urandom_range(0, 1));
            end
        endtask

        task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input int gap);
            int n;
            for (int i = 0; i < gap; i++) idle_cycle();
            @(negedge clk);
            n = 0;
            while (!in_ready && n < 2000) begin
                in_valid = 1'($urandom_range(0, 1));
                a        = W'($urandom);
                b        = W'($urandom);
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                in_valid = 1'b0;
                fail_now(W, "accept timeout");
            end else begin
                in_valid = 1'b1;
                a        = ta;
                b        = tb_;
                cin      = tc;
                exp_q.push_back({1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc});
                acc_q.push_back(cyc + 1);
                idle_cycle();
            end
        endtask

        task automatic drain();
            int n;
            n = 0;
            while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
                idle_cycle();
                n++;
            end
            idle_cycle();
            chk(W, "drain queue empty", exp_q.size(), 0);
        endtask

        task automatic sb_reset();
            exp_q.delete();
            acc_q.delete();
            seen    = 1'b0;
            prev_hs = 1'b0;
        endtask

        initial begin
            int n;
            rst_n     = 1'b1;
            in_valid  = 1'b0;
            a         = '0;
            b         = '0;
            cin       = 1'b0;
            out_ready = 1'b1;
            or_mode   = 0;
            seen      = 1'b0;
            prev_hs   = 1'b0;
            held      = '0;
            #1 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk(W, "reset in_ready", in_ready, 1);
            chk(W, "reset out_valid", out_valid, 0);
            chk(W, "reset sum", sum, 0);
            chk(W, "reset cout", cout, 0);
            chk(W, "reset state", state_dbg, 0);
            @(negedge clk) rst_n = 1'b1;

            // Directed adds and carry chains, out_ready held high
            send(W'(32'h1234), W'(32'h4321), 1'b0, 0);
            send(W'(32'hFFFF), W'(32'h0001), 1'b0, 0);
            send(W'(32'hFFFF), W'(32'h0000), 1'b1, 0);
            send(W'(32'h8000), W'(32'h8000), 1'b0, 0);
            send({W{1'b1}}, {{(W-1){1'b0}}, 1'b1}, 1'b0, 1);
            send({W{1'b1}}, {W{1'b1}}, 1'b1, 0);
            drain();

            // Backpressure with junk offered during RUN and DONE
            or_mode = 1;
            send(W'(32'hA5C3), W'(32'h5A3D), 1'b1, 0);
            n = 0;
            while (!out_valid && n < 200) begin
                idle_cycle();
                n++;
            end
            repeat (6) idle_cycle();
            chk(W, "bp out_valid held", out_valid, 1);
            chk(W, "bp in_ready low", in_ready, 0);
            or_mode = 0;
            drain();

            // Asynchronous reset in the middle of RUN
            send(W'(32'h1234), W'(32'h1111), 1'b0, 0);
            repeat (KMID) @(posedge clk);
            #1;
            chk(W, "pre-reset state RUN", state_dbg, 1);
            rst_n    = 1'b0;
            in_valid = 1'b0;
            sb_reset();
            #1;
            chk(W, "midreset in_ready", in_ready, 1);
            chk(W, "midreset out_valid", out_valid, 0);
            chk(W, "midreset sum", sum, 0);
            chk(W, "midreset cout", cout, 0);
            @(negedge clk) rst_n = 1'b1;
            send(W'(32'h0F0F), W'(32'h00F1), 1'b0, 0);
            drain();

            // Randomized traffic with random input gaps and out_ready
            or_mode = 2;
            for (int t = 0; t < 1000; t++) begin
                logic [W-1:0] ra;
                logic [W-1:0] rb;
                ra = W'($urandom);
                rb = W'($urandom);
                if (t % 16 == 0) ra = {W{1'b1}};
                send(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end
            or_mode = 0;
            drain();
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 90000 && done_cnt < 3; i++) @(posedge clk);
        if (done_cnt < 3) fail_now(0, "global timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
